// File: rtl/uart_term_pkg.sv
// Shared constants and state encoding for the terminal read-port line editor.
package uart_term_pkg;

    localparam logic [7:0] EOF      = 8'hFF;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] DEL      = 8'h7F;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        S_EDIT = 2'd0,
        S_ECHO = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        E_CHAR    = 2'd0,
        E_RUBOUT  = 2'd1,
        E_NEWLINE = 2'd2
    } echo_kind_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/line_buf_ram.sv
// DEPTH x 8 simple dual-port line buffer: editor writes, registered read port for the consumer.
module line_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_line_editor.sv
// Line editor for the terminal read port: edits UART RX bytes into one EOF-terminated line.
// Define ECHO_EN to echo edits toward the UART transmitter; otherwise echo outputs are tied low.
module uart_line_editor
    import uart_term_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [7:0]    in_data_i,
    output logic          echo_valid_o,
    input  logic          echo_ready_i,
    output logic [7:0]    echo_data_o,
    output logic          r_ready_o,
    input  logic          r_valid_i,
    input  logic [AW-1:0] r_addr_i,
    output logic [7:0]    r_data_o,
    output logic          r_last_o,
    output logic          overflow_o
);

    state_t        state_q;
    logic [AW-1:0] len_q;
    logic          overflow_q;
    logic          rd_pend_q;

    logic          accept;
    logic          is_print;
    logic          is_rub;
    logic          is_eol;
    logic          full;
    logic          rd_fire;
    logic          line_done;
    logic          buf_we;
    logic [7:0]    buf_wdata;
    logic [7:0]    rd_data;

    assign in_ready_o = (state_q == S_EDIT);
    assign r_ready_o  = (state_q == S_HOLD);
    assign overflow_o = overflow_q;
    assign r_data_o   = rd_data;

    assign accept   = in_valid_i & in_ready_o;
    assign is_print = is_printable(in_data_i);
    assign is_rub   = (in_data_i == BS) || (in_data_i == DEL);
    assign is_eol   = (in_data_i == CR) || (in_data_i == LF);
    assign full     = (len_q == AW'(DEPTH - 1));

    // The line is released by the response that returns EOF; a fire in that same cycle is dropped.
    assign line_done = rd_pend_q & (rd_data == EOF);
    assign rd_fire   = r_valid_i & r_ready_o & ~line_done;
    assign r_last_o  = line_done;

    assign buf_we    = accept & ((is_print & ~full) | is_eol);
    assign buf_wdata = is_eol ? EOF : in_data_i;

    line_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (buf_we),
        .waddr_i (len_q),
        .wdata_i (buf_wdata),
        .re_i    (rd_fire),
        .raddr_i (r_addr_i),
        .rdata_o (rd_data)
    );

`ifdef ECHO_EN
    echo_kind_t echo_kind_q;
    logic [1:0] echo_idx_q;
    logic [7:0] echo_char_q;
    logic       echo_valid_q;
    logic [7:0] echo_data_q;
    logic       echo_start;
    echo_kind_t start_kind;

    function automatic logic [7:0] echo_byte(input echo_kind_t kind, input logic [1:0] idx,
                                             input logic [7:0] ch);
        case (kind)
            E_CHAR:   echo_byte = ch;
            E_RUBOUT: echo_byte = (idx == 2'd1) ? 8'h20 : BS;
            default:  echo_byte = (idx == 2'd0) ? CR : LF;
        endcase
    endfunction

    function automatic logic [1:0] echo_last(input echo_kind_t kind);
        case (kind)
            E_CHAR:   echo_last = 2'd0;
            E_RUBOUT: echo_last = 2'd2;
            default:  echo_last = 2'd1;
        endcase
    endfunction

    always_comb begin
        echo_start = (is_print & ~full) | (is_rub & (len_q != '0)) | is_eol;
        start_kind = E_NEWLINE;
        if (is_print) begin
            start_kind = E_CHAR;
        end else if (is_rub) begin
            start_kind = E_RUBOUT;
        end
    end

    assign echo_valid_o = echo_valid_q;
    assign echo_data_o  = echo_data_q;
`else
    logic unused_echo;
    assign unused_echo  = echo_ready_i;
    assign echo_valid_o = 1'b0;
    assign echo_data_o  = 8'h00;
`endif

    // Editing FSM: one RX byte per accept, an optional echo burst, then hold the line for reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_EDIT;
            len_q      <= '0;
            overflow_q <= 1'b0;
            rd_pend_q  <= 1'b0;
`ifdef ECHO_EN
            echo_kind_q  <= E_CHAR;
            echo_idx_q   <= 2'd0;
            echo_char_q  <= 8'h00;
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'h00;
`endif
        end else begin
            rd_pend_q <= rd_fire;
            case (state_q)
                S_EDIT: begin
                    if (accept) begin
                        if (is_print && !full) begin
                            len_q <= len_q + AW'(1);
                        end
                        if (is_print && full) begin
                            overflow_q <= 1'b1;
                        end
                        if (is_rub && (len_q != '0)) begin
                            len_q <= len_q - AW'(1);
                        end
                        if (is_eol) begin
                            overflow_q <= 1'b0;
                        end
`ifdef ECHO_EN
                        if (echo_start) begin
                            state_q      <= S_ECHO;
                            echo_kind_q  <= start_kind;
                            echo_idx_q   <= 2'd0;
                            echo_char_q  <= in_data_i;
                            echo_valid_q <= 1'b1;
                            echo_data_q  <= echo_byte(start_kind, 2'd0, in_data_i);
                        end
`else
                        if (is_eol) begin
                            state_q <= S_HOLD;
                        end
`endif
                    end
                end
`ifdef ECHO_EN
                S_ECHO: begin
                    if (echo_ready_i) begin
                        if (echo_idx_q == echo_last(echo_kind_q)) begin
                            echo_valid_q <= 1'b0;
                            echo_data_q  <= 8'h00;
                            state_q      <= (echo_kind_q == E_NEWLINE) ? S_HOLD : S_EDIT;
                        end else begin
                            echo_idx_q  <= echo_idx_q + 2'd1;
                            echo_data_q <= echo_byte(echo_kind_q, echo_idx_q + 2'd1, echo_char_q);
                        end
                    end
                end
`endif
                S_HOLD: begin
                    if (line_done) begin
                        state_q <= S_EDIT;
                        len_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_EDIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_editor.sv
// Self-checking bench for uart_line_editor: queue-based reference model plus directed line scenarios.
`timescale 1ns/1ps
module tb_uart_line_editor;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef ECHO_EN
    localparam bit ECHO_ON = 1'b1;
`else
    localparam bit ECHO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [7:0]    inData = 8'h00;
    logic          echoValid;
    logic          echoReady = 1'b1;
    logic [7:0]    echoData;
    logic          rReady;
    logic          rValid = 1'b0;
    logic [AW-1:0] rAddr = '0;
    logic [7:0]    rData;
    logic          rLast;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    uart_line_editor #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (inValid),
        .in_ready_o   (inReady),
        .in_data_i    (inData),
        .echo_valid_o (echoValid),
        .echo_ready_i (echoReady),
        .echo_data_o  (echoData),
        .r_ready_o    (rReady),
        .r_valid_i    (rValid),
        .r_addr_i     (rAddr),
        .r_data_o     (rData),
        .r_last_o     (rLast),
        .overflow_o   (overflow)
    );

    // Reference model: the line as an array, pending echo as a byte queue, holding as a flag.
    logic [7:0] mBuf [DEPTH];
    int         mLen = 0;
    bit         mOverflow = 1'b0;
    bit         mHolding = 1'b0;
    bit         mCommitAfterEcho = 1'b0;
    logic [7:0] mEcho [$];
    logic [7:0] mRData = 8'h00;
    bit         mRLast = 1'b0;
    logic [7:0] echoLog [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelAccept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mLen < DEPTH - 1) begin
                mBuf[mLen] = b;
                mLen++;
                if (ECHO_ON) mEcho.push_back(b);
            end else begin
                mOverflow = 1'b1;
            end
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mLen > 0) begin
                mLen--;
                if (ECHO_ON) begin
                    mEcho.push_back(8'h08);
                    mEcho.push_back(8'h20);
                    mEcho.push_back(8'h08);
                end
            end
        end else if (b == 8'h0D || b == 8'h0A) begin
            mBuf[mLen] = 8'hFF;
            mOverflow = 1'b0;
            if (ECHO_ON) begin
                mEcho.push_back(8'h0D);
                mEcho.push_back(8'h0A);
                mCommitAfterEcho = 1'b1;
            end else begin
                mHolding = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin : model
        bit canAccept;
        bit fire;
        bit wasLast;
        if (rst) begin
            mLen = 0;
            mOverflow = 1'b0;
            mHolding = 1'b0;
            mCommitAfterEcho = 1'b0;
            mEcho.delete();
            mRData = 8'h00;
            mRLast = 1'b0;
        end else begin
            canAccept = !mHolding && (mEcho.size() == 0);
            wasLast = mRLast;
            fire = mHolding && rValid && !wasLast;
            mRLast = fire && (mBuf[rAddr] == 8'hFF);
            if (fire) mRData = mBuf[rAddr];
            if (wasLast) begin
                mHolding = 1'b0;
                mLen = 0;
            end
            if (mEcho.size() > 0 && echoReady) begin
                void'(mEcho.pop_front());
                if (mEcho.size() == 0 && mCommitAfterEcho) begin
                    mHolding = 1'b1;
                    mCommitAfterEcho = 1'b0;
                end
            end
            if (canAccept && inValid) modelAccept(inData);
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", {31'd0, inReady}, {31'd0, (!mHolding && mEcho.size() == 0)});
            checkOutput("echo_valid", {31'd0, echoValid}, {31'd0, (mEcho.size() > 0)});
            if (mEcho.size() > 0) checkOutput("echo_data", {24'd0, echoData}, {24'd0, mEcho[0]});
            checkOutput("r_ready", {31'd0, rReady}, {31'd0, mHolding});
            checkOutput("r_data", {24'd0, rData}, {24'd0, mRData});
            checkOutput("r_last", {31'd0, rLast}, {31'd0, mRLast});
            checkOutput("overflow", {31'd0, overflow}, {31'd0, mOverflow});
            if (echoValid && echoReady) echoLog.push_back(echoData);
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        inValid = 1'b1;
        inData  = b;
        while (1) begin
            @(negedge clk);
            if (inReady) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: in_ready %0b after %0d cycles, required 1", inReady, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic readAddr(input logic [AW-1:0] a, output logic [7:0] d, output logic l);
        int n;
        n = 0;
        rValid = 1'b1;
        rAddr  = a;
        while (1) begin
            @(negedge clk);
            if (rReady) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL read_timeout: r_ready %0b after %0d cycles, required 1", rReady, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        rValid = 1'b0;
        @(negedge clk);
        d = rData;
        l = rLast;
        @(posedge clk);
        #1;
    endtask

    task automatic readExpect(input string name, input logic [AW-1:0] a, input logic [7:0] expD, input logic expL);
        logic [7:0] d;
        logic l;
        readAddr(a, d, l);
        checkOutput({name, "_data"}, {24'd0, d}, {24'd0, expD});
        checkOutput({name, "_last"}, {31'd0, l}, {31'd0, expL});
    endtask

    task automatic checkEcho(input string name, input logic [7:0] exp [$]);
        if (!ECHO_ON) exp.delete();
        checkOutput({name, "_len"}, echoLog.size(), exp.size());
        foreach (exp[i]) begin
            if (i < echoLog.size()) checkOutput(name, {24'd0, echoLog[i]}, {24'd0, exp[i]});
        end
        echoLog.delete();
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_echo_valid", {31'd0, echoValid}, 32'd0);
        checkOutput("rst_echo_data", {24'd0, echoData}, 32'd0);
        checkOutput("rst_r_ready", {31'd0, rReady}, 32'd0);
        checkOutput("rst_r_data", {24'd0, rData}, 32'd0);
        checkOutput("rst_r_last", {31'd0, rLast}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        echoLog.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [7:0] q [$];
        int n;

        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        pulseReset();

        // 1: "42" then CR
        applyStimulus(8'h34);
        applyStimulus(8'h32);
        applyStimulus(8'h0D);
        readExpect("t1_a0", 4'd0, 8'h34, 1'b0);
        readExpect("t1_a1", 4'd1, 8'h32, 1'b0);
        readExpect("t1_a2", 4'd2, 8'hFF, 1'b1);
        q = {8'h34, 8'h32, 8'h0D, 8'h0A};
        checkEcho("t1_echo", q);

        // 2: backspace on empty line, then "7x<BS>5"
        applyStimulus(8'h08);
        repeat (3) @(posedge clk);
        #1;
        q = {};
        checkEcho("t2_bs_empty", q);
        applyStimulus(8'h37);
        applyStimulus(8'h78);
        applyStimulus(8'h08);
        applyStimulus(8'h35);
        applyStimulus(8'h0D);
        readExpect("t2_a1", 4'd1, 8'h35, 1'b0);
        readExpect("t2_a0", 4'd0, 8'h37, 1'b0);
        readExpect("t2_a0r", 4'd0, 8'h37, 1'b0);
        readExpect("t2_a2", 4'd2, 8'hFF, 1'b1);
        q = {8'h37, 8'h78, 8'h08, 8'h20, 8'h08, 8'h35, 8'h0D, 8'h0A};
        checkEcho("t2_echo", q);

        // 3: overflow with 20 printable bytes
        for (int i = 0; i < 20; i++) applyStimulus(8'h41);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_ovf_set", {31'd0, overflow}, 32'd1);
        applyStimulus(8'h0D);
        @(negedge clk);
        checkOutput("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        readExpect("t3_a0", 4'd0, 8'h41, 1'b0);
        readExpect("t3_a14", 4'd14, 8'h41, 1'b0);
        readExpect("t3_a15", 4'd15, 8'hFF, 1'b1);
        q = {};
        for (int i = 0; i < 15; i++) q.push_back(8'h41);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        checkEcho("t3_echo", q);

        // 4: RX byte held off while the line is readable
        applyStimulus(8'h39);
        applyStimulus(8'h0D);
        fork
            applyStimulus(8'h38);
            begin
                readExpect("t4_a0", 4'd0, 8'h39, 1'b0);
                readExpect("t4_a1", 4'd1, 8'hFF, 1'b1);
            end
        join
        applyStimulus(8'h0D);
        readExpect("t4_b0", 4'd0, 8'h38, 1'b0);
        readExpect("t4_b1", 4'd1, 8'hFF, 1'b1);
        echoLog.delete();

        // 5: transmitter stalls for 10 cycles
        echoReady = 1'b0;
        applyStimulus(8'h6D);
        repeat (10) @(negedge clk);
        checkOutput("t5_stall_valid", {31'd0, echoValid}, {31'd0, ECHO_ON});
        checkOutput("t5_stall_inready", {31'd0, inReady}, {31'd0, !ECHO_ON});
        @(posedge clk);
        #1;
        echoReady = 1'b1;
        applyStimulus(8'h0D);
        readExpect("t5_a0", 4'd0, 8'h6D, 1'b0);
        readExpect("t5_a1", 4'd1, 8'hFF, 1'b1);
        q = {8'h6D, 8'h0D, 8'h0A};
        checkEcho("t5_echo", q);

        // 6: reset mid-line (DEL also rubs out) and reset while holding
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        applyStimulus(8'h7F);
        applyStimulus(8'h63);
        applyStimulus(8'h64);
        pulseReset();
        applyStimulus(8'h5A);
        applyStimulus(8'h0A);
        readExpect("t6_a0", 4'd0, 8'h5A, 1'b0);
        readExpect("t6_a1", 4'd1, 8'hFF, 1'b1);
        applyStimulus(8'h51);
        applyStimulus(8'h0D);
        n = 0;
        while (!rReady && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t6_hold_reached", {31'd0, rReady}, 32'd1);
        pulseReset();
        applyStimulus(8'hFF);
        applyStimulus(8'h6B);
        applyStimulus(8'h0D);
        readExpect("t6_b0", 4'd0, 8'h6B, 1'b0);
        readExpect("t6_b1", 4'd1, 8'hFF, 1'b1);
        q = {8'h6B, 8'h0D, 8'h0A};
        checkEcho("t6_echo", q);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
